// File: rtl/tmds_pkg.sv
// TMDS shared definitions: control tokens, aligner state encoding, data decode helpers.
// Latency: n/a (constants and combinational functions only).
// Backpressure: n/a. Intended to be shared by the encoder and decoder sides.
package tmds_pkg;

  // Control-period tokens, written MSB..LSB; bit0 is the first bit on the wire.
  localparam logic [9:0] TMDS_TOK_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_TOK_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_TOK_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_TOK_11 = 10'b1010101011;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  function automatic logic tmds_is_token(input logic [9:0] sym);
    return (sym == TMDS_TOK_00) || (sym == TMDS_TOK_01) ||
           (sym == TMDS_TOK_10) || (sym == TMDS_TOK_11);
  endfunction

  function automatic logic [1:0] tmds_token_ctrl(input logic [9:0] sym);
    logic [1:0] c;
    c = 2'b00;
    case (sym)
      TMDS_TOK_01: c = 2'b01;
      TMDS_TOK_10: c = 2'b10;
      TMDS_TOK_11: c = 2'b11;
      default:     c = 2'b00;
    endcase
    return c;
  endfunction

  // Undo the optional inversion (bit9), then the XOR/XNOR transition stage (bit8).
  function automatic logic [7:0] tmds_decode_data(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] q;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    q    = 8'h00;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// TMDS word aligner: slices 10-bit symbols out of a 20-bit window and locks the offset on control-token runs.
// Latency: 1 cycle from the word holding a symbol's last bit to sym_q/tok_hit.
// Backpressure: none; one word accepted every pix_clk.
// Ports: pix_clk, rst_n (async, active-low); tmds_word raw deserialized word;
//   sym_q registered slice; tok_hit sym_q is a control token; locked; offset 0..9.
//   With TMDS_SLIP_CNT_EN: cnt_clr (sync clear) and slip_cnt (saturating slip/loss event count).
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN     = 8,
  parameter int unsigned SEARCH_WIN   = 1024,
  parameter int unsigned LOSS_TIMEOUT = 2048
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic [9:0]  tmds_word,
`ifdef TMDS_SLIP_CNT_EN
  input  logic        cnt_clr,
  output logic [15:0] slip_cnt,
`endif
  output logic [9:0]  sym_q,
  output logic        tok_hit,
  output logic        locked,
  output logic [3:0]  offset
);

  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned WIN_W  = $clog2(SEARCH_WIN);
  localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT);

  localparam logic [RUN_W-1:0]  RUN_ONE  = 1;
  localparam logic [WIN_W-1:0]  WIN_ONE  = 1;
  localparam logic [LOSS_W-1:0] LOSS_ONE = 1;

  align_state_t      state, state_nxt;
  logic [9:0]        prev_word;
  logic [19:0]       window;
  logic [9:0]        sym;
  logic [3:0]        offset_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [WIN_W-1:0]  win_cnt, win_nxt;
  logic [LOSS_W-1:0] loss_cnt, loss_nxt;

  // Older word sits in the low half so that bit0 of the window is the earliest bit.
  assign window  = {tmds_word, prev_word};
  assign sym     = window[{1'b0, offset} +: 10];
  assign tok_hit = tmds_is_token(sym_q);
  assign locked  = (state == LOCKED);

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    run_nxt    = run_cnt;
    win_nxt    = win_cnt;
    loss_nxt   = loss_cnt;
    case (state)
      SEARCH: begin
        run_nxt = !tok_hit ? '0 : ((run_cnt == '1) ? run_cnt : run_cnt + RUN_ONE);
        win_nxt = (win_cnt == '1) ? win_cnt : win_cnt + WIN_ONE;
        // Lock takes precedence over a slip falling due in the same cycle.
        if (run_nxt >= RUN_W'(CTRL_RUN)) begin
          state_nxt = LOCKED;
          run_nxt   = '0;
          win_nxt   = '0;
          loss_nxt  = '0;
        end else if (win_cnt == WIN_W'(SEARCH_WIN - 1)) begin
          offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          run_nxt    = '0;
          win_nxt    = '0;
        end
      end
      LOCKED: begin
        loss_nxt = tok_hit ? '0 : ((loss_cnt == '1) ? loss_cnt : loss_cnt + LOSS_ONE);
        // Offset is kept on loss: the link most likely came back at the same alignment.
        if (loss_cnt == LOSS_W'(LOSS_TIMEOUT - 1)) begin
          state_nxt = SEARCH;
          run_nxt   = '0;
          win_nxt   = '0;
          loss_nxt  = '0;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      prev_word <= '0;
      sym_q     <= '0;
      offset    <= '0;
      run_cnt   <= '0;
      win_cnt   <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      prev_word <= tmds_word;
      sym_q     <= sym;
      offset    <= offset_nxt;
      run_cnt   <= run_nxt;
      win_cnt   <= win_nxt;
      loss_cnt  <= loss_nxt;
    end
  end

`ifdef TMDS_SLIP_CNT_EN
  logic slip_evt;
  assign slip_evt = (offset_nxt != offset) || (state == LOCKED && state_nxt == SEARCH);

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_cnt <= '0;
    end else if (cnt_clr) begin
      slip_cnt <= '0;
    end else if (slip_evt && slip_cnt != 16'hFFFF) begin
      slip_cnt <= slip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment plus decode of pixel byte, control bits and DE.
// Latency: 2 cycles from the word carrying a symbol's last bit to o_data/o_ctrl/o_de.
// Backpressure: none; one word per i_pix_clk, outputs update every cycle.
// Ports: i_pix_clk, i_rst_n (async, active-low); i_tmds_word raw word (bit0 earliest);
//   o_data, o_ctrl {c1,c0} ({vsync,hsync} on channel 0), o_de, o_locked, o_offset.
//   Optional TMDS_SLIP_CNT_EN adds i_cnt_clr and o_slip_cnt.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN     = 8,
  parameter int unsigned SEARCH_WIN   = 1024,
  parameter int unsigned LOSS_TIMEOUT = 2048
) (
  input  logic        i_pix_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_tmds_word,
`ifdef TMDS_SLIP_CNT_EN
  input  logic        i_cnt_clr,
  output logic [15:0] o_slip_cnt,
`endif
  output logic [7:0]  o_data,
  output logic [1:0]  o_ctrl,
  output logic        o_de,
  output logic        o_locked,
  output logic [3:0]  o_offset
);

  logic [9:0] sym_q;
  logic       tok_hit;
  logic       locked;

  tmds_word_aligner #(
    .CTRL_RUN     (CTRL_RUN),
    .SEARCH_WIN   (SEARCH_WIN),
    .LOSS_TIMEOUT (LOSS_TIMEOUT)
  ) u_aligner (
    .pix_clk   (i_pix_clk),
    .rst_n     (i_rst_n),
    .tmds_word (i_tmds_word),
`ifdef TMDS_SLIP_CNT_EN
    .cnt_clr   (i_cnt_clr),
    .slip_cnt  (o_slip_cnt),
`endif
    .sym_q     (sym_q),
    .tok_hit   (tok_hit),
    .locked    (locked),
    .offset    (o_offset)
  );

  assign o_locked = locked;

  // Stage 2. o_data only ever changes on a decoded data symbol, so it holds
  // the last pixel across blanking and while unlocked.
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
      o_ctrl <= '0;
      o_de   <= 1'b0;
    end else if (!locked) begin
      o_ctrl <= 2'b00;
      o_de   <= 1'b0;
    end else if (tok_hit) begin
      o_ctrl <= tmds_token_ctrl(sym_q);
      o_de   <= 1'b0;
    end else begin
      o_data <= tmds_decode_data(sym_q);
      o_de   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: serialises symbols at a chosen bit
// alignment, drives them as raw words and compares outputs against a local encoder/model.
module tb_tmds_channel_decoder;

  localparam int CTRL_RUN     = 8;
  localparam int SEARCH_WIN   = 1024;
  localparam int LOSS_TIMEOUT = 2048;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic       pix_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] tmds_word = '0;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_locked;
  logic [3:0] o_offset;
`ifdef TMDS_SLIP_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] slip_cnt;
  logic [15:0] slip_base;
`endif

  tmds_channel_decoder dut (
    .i_pix_clk   (pix_clk),
    .i_rst_n     (rst_n),
    .i_tmds_word (tmds_word),
`ifdef TMDS_SLIP_CNT_EN
    .i_cnt_clr   (i_cnt_clr_w),
    .o_slip_cnt  (slip_cnt),
`endif
    .o_data      (o_data),
    .o_ctrl      (o_ctrl),
    .o_de        (o_de),
    .o_locked    (o_locked),
    .o_offset    (o_offset)
  );
`ifdef TMDS_SLIP_CNT_EN
  logic i_cnt_clr_w;
  assign i_cnt_clr_w = cnt_clr;
`endif

  always #5 pix_clk = ~pix_clk;

  int checks = 0;
  int errors = 0;

  // Serialiser state: stream bit 10k+align carries bit0 of symbol k.
  int         align = 3;
  logic [9:0] prev_sym = '0;

  // Output model and a 3-deep history of its expected {de,ctrl,data}.
  logic        m_de   = 1'b0;
  logic [1:0]  m_ctrl = 2'b00;
  logic [7:0]  m_data = 8'h00;
  logic [10:0] hist [3];

  typedef struct {
    logic [9:0] sym;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder; inv chooses the bit9 inversion so both decode paths are exercised.
  function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
    logic [8:0] qm;
    int n1;
    n1    = $countones(d);
    qm    = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  function automatic logic [9:0] tok_of(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = T0;
      2'b01:   t = T1;
      2'b10:   t = T2;
      default: t = T3;
    endcase
    return t;
  endfunction

  task automatic step(input logic [9:0] sym);
    logic [19:0] pair;
    pair      = {sym, prev_sym} >> (10 - align);
    tmds_word = pair[9:0];
    prev_sym  = sym;
    @(posedge pix_clk);
    #1;
  endtask

  task automatic mstep(input logic tok, input logic [1:0] c, input logic [7:0] d, input logic [9:0] sym);
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (tok) begin
      m_de   = 1'b0;
      m_ctrl = c;
    end else begin
      m_de   = 1'b1;
      m_data = d;
    end
    hist[0] = {m_de, m_ctrl, m_data};
    step(sym);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pix;
    logic [1:0] lc;
    int de_cnt, bad, unl, k;

    // ---------------- reset state ----------------
    align = 3;
    step(T0);
    step(T0);
    check("reset_outputs", {o_data, o_ctrl, o_de, o_locked, o_offset}, 0);
    rst_n = 1'b1;

    // ---------------- lock at offset 3 ----------------
    k = 0;
    while (!o_locked && k < 3 * SEARCH_WIN + CTRL_RUN + 2) begin
      step(T0);
      k++;
    end
    check("lock_time", o_locked, 1);
    check("lock_offset", o_offset, 3);
    step(T0);
    step(T0);
    check("lock_ctrl", o_ctrl, 2'b00);
    check("lock_de", o_de, 0);

    // ---------------- data decode (table) ----------------
    tbl[0] = '{T0,             1'b0, 2'b00, 8'h00};
    tbl[1] = '{T0,             1'b0, 2'b00, 8'h00};
    tbl[2] = '{enc(8'h00, 0),  1'b1, 2'b00, 8'h00};
    tbl[3] = '{enc(8'hFF, 1),  1'b1, 2'b00, 8'hFF};
    tbl[4] = '{enc(8'h55, 0),  1'b1, 2'b00, 8'h55};
    tbl[5] = '{enc(8'hA7, 1),  1'b1, 2'b00, 8'hA7};
    tbl[6] = '{T2,             1'b0, 2'b10, 8'hA7};
    tbl[7] = '{T2,             1'b0, 2'b10, 8'hA7};
    tbl[8] = '{T2,             1'b0, 2'b10, 8'hA7};
    for (int i = 0; i < 11; i++) begin
      step(i < 9 ? tbl[i].sym : T2);
      if (i >= 2)
        check($sformatf("vec%0d", i - 2), {o_de, o_ctrl, o_data},
              {tbl[i-2].de, tbl[i-2].ctrl, tbl[i-2].data});
    end

    // ---------------- sync recovery: 10 lines of 640 data + 160 tokens ----------------
    m_de = 1'b0; m_ctrl = 2'b10; m_data = 8'hA7;
    for (int h = 0; h < 3; h++) hist[h] = {m_de, m_ctrl, m_data};
    for (int l = 0; l < 10; l++) begin
      de_cnt = 0; bad = 0; unl = 0;
      lc = (l % 3 == 0) ? 2'b00 : ((l % 3 == 1) ? 2'b01 : 2'b11);
      for (int p = 0; p < 800; p++) begin
        if (p < 640) begin
          pix = 8'(p) ^ 8'(l * 37);
          mstep(1'b0, 2'b00, pix, enc(pix, p[0]));
        end else begin
          mstep(1'b1, lc, 8'h00, tok_of(lc));
        end
        if (o_de) de_cnt++;
        if ({o_de, o_ctrl, o_data} !== hist[2]) bad++;
        if (!o_locked) unl++;
      end
      check($sformatf("line%0d_de_cycles", l), de_cnt, 640);
      check($sformatf("line%0d_mismatch_cycles", l), bad, 0);
      check($sformatf("line%0d_unlocked_cycles", l), unl, 0);
    end

    // ---------------- loss of lock ----------------
    for (int i = 0; i < LOSS_TIMEOUT - 1; i++) step(enc(8'h3C, 1'b0));
    check("loss_still_locked", o_locked, 1);
    k = LOSS_TIMEOUT - 1;
    while (o_locked && k < LOSS_TIMEOUT + 4) begin
      step(enc(8'h3C, 1'b0));
      k++;
    end
    check("loss_dropped", o_locked, 0);
    step(enc(8'h3C, 1'b0));
    step(enc(8'h3C, 1'b0));
    step(enc(8'h3C, 1'b0));
    check("loss_de_forced", o_de, 0);
    check("loss_offset_kept", o_offset, 3);
    k = 0;
    while (!o_locked && k < CTRL_RUN + 6) begin
      step(T0);
      k++;
    end
    check("relock", {o_locked, o_offset}, {1'b1, 4'd3});

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 4; i++) step(enc(8'h5A, 1'b1));
    check("pre_reset_data", {o_de, o_data}, {1'b1, 8'h5A});
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {o_data, o_ctrl, o_de, o_locked, o_offset}, 0);
`ifdef TMDS_SLIP_CNT_EN
    check("async_reset_slip_cnt", slip_cnt, 0);
`endif
    #2 rst_n = 1'b1;
    step(T0);
    step(T0);
    check("post_reset_search", {o_locked, o_offset}, 0);

    // ---------------- offset wrap 9 -> 0 ----------------
    align = 9;
    k = 0;
    while (!o_locked && k < 10 * SEARCH_WIN + CTRL_RUN + 4) begin
      step(T0);
      k++;
    end
    check("lock_at_9", {o_locked, o_offset}, {1'b1, 4'd9});
`ifdef TMDS_SLIP_CNT_EN
    slip_base = slip_cnt;
`endif
    align = 0;
    k = 0;
    while (o_locked && k < LOSS_TIMEOUT + 8) begin
      step(T0);
      k++;
    end
    check("wrap_loss", {o_locked, o_offset}, {1'b0, 4'd9});
    k = 0;
    while (!o_locked && k < SEARCH_WIN + CTRL_RUN + 8) begin
      step(T0);
      k++;
    end
    check("wrap_lock_at_0", {o_locked, o_offset}, {1'b1, 4'd0});
`ifdef TMDS_SLIP_CNT_EN
    check("slip_cnt_delta", 16'(slip_cnt - slip_base), 2);
    cnt_clr = 1'b1;
    step(T0);
    cnt_clr = 1'b0;
    check("slip_cnt_clear", slip_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
